// File: rtl/conv_blk_ctrl_pkg.sv
// conv_blk_ctrl shared definitions: widths, state codes, geometry helpers.
// Geometry helpers are constant functions usable in port widths.
package conv_pkg;

  localparam int FM_W_D  = 30;
  localparam int W_W_D   = 18;
  localparam int ACC_W_D = 48;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_WLOAD  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  function automatic int out_size(
    int fm, int k, int pad, int stride
  );
    return ((fm - k + 2 * pad) / stride) + 1;
  endfunction

  function automatic int n_out(
    int osz, int maxpool
  );
    return (maxpool != 0) ?
      (osz / 2) * (osz / 2) : osz * osz;
  endfunction

  function automatic int cw(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_blk_ctrl_if.sv
// Link between the sequencer (master) and one conv_blk (slave).
// Carries clear, weight load, feature-map stream and result return.
interface conv_blk_ctrl_if
  import conv_pkg::*;
#(
  parameter int FM_W  = FM_W_D,
  parameter int W_W   = W_W_D,
  parameter int ACC_W = ACC_W_D
) ();

  logic             blk_rst;
  logic             weight_en;
  logic [W_W-1:0]   weight_data;
  logic             go;
  logic [FM_W-1:0]  fm_data;
  logic             blk_en;
  logic [ACC_W-1:0] blk_result;

  modport master (
    output blk_rst, weight_en, weight_data,
    output go, fm_data,
    input  blk_en, blk_result
  );

  modport slave (
    input  blk_rst, weight_en, weight_data,
    input  go, fm_data,
    output blk_en, blk_result
  );

endinterface

// File: rtl/conv_blk_ctrl_seq_cnt.sv
// Up-counter with clear, enable and saturation at MAX.
// o_tc is high while the count sits at MAX.
module seq_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q,
  output logic         o_tc
);

  assign o_tc = (o_q == W'(MAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_clr) begin
      o_q <= '0;
    end else if (i_en && !o_tc) begin
      o_q <= o_q + 1'b1;
    end
  end

endmodule

// File: rtl/conv_blk_ctrl.sv
// Single-layer sequencer for conv_blk: clear, weight load,
// feature-map stream, result drain into the output BRAM.
module conv_blk_ctrl
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 252,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1,
  parameter int MAXPOOL     = 0,
  parameter int FM_W        = FM_W_D,
  parameter int W_W         = W_W_D,
  parameter int ACC_W       = ACC_W_D,
  parameter int TIMEOUT     = 4096
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
  output logic o_err,
  output logic [cw(KERNEL_SIZE*KERNEL_SIZE)-1:0]
               o_wt_rd_addr,
  input  logic [W_W-1:0] i_wt_rd_data,
  output logic [cw(FM_SIZE*FM_SIZE)-1:0]
               o_fm_rd_addr,
  input  logic [FM_W-1:0] i_fm_rd_data,
  output logic o_blk_rst,
  output logic o_weight_en,
  output logic [W_W-1:0] o_weight_data,
  output logic o_go,
  output logic [FM_W-1:0] o_fm_data,
  input  logic i_blk_en,
  input  logic [ACC_W-1:0] i_blk_result,
  output logic o_out_wr_en,
  output logic [cw(n_out(out_size(FM_SIZE,
    KERNEL_SIZE, PADDING, STRIDE), MAXPOOL))-1:0]
               o_out_wr_addr,
  output logic [ACC_W-1:0] o_out_wr_data
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int FMN   = FM_SIZE * FM_SIZE;
  localparam int OSZ   = out_size(FM_SIZE,
    KERNEL_SIZE, PADDING, STRIDE);
  localparam int N_OUT = n_out(OSZ, MAXPOOL);
  localparam int WA_W  = cw(KK);
  localparam int FA_W  = cw(FMN);
  localparam int OA_W  = cw(N_OUT);
  localparam int OC_W  = $clog2(N_OUT + 1);
  localparam int WD_W  = cw(TIMEOUT);

  logic [2:0]      state, nxt;
  logic            ph, w_last;
  logic [WA_W-1:0] wa;
  logic [FA_W-1:0] fa;
  logic [OC_W-1:0] oc;
  logic [WD_W-1:0] wd;
  logic            wa_tc, fa_tc, oc_tc, wd_tc;
  logic            live, w_iss, cap;
  logic            oc_hit, wd_hit;

  assign live  = (state == S_STREAM) ||
                 (state == S_DRAIN);
  assign w_iss = (state == S_WLOAD) && !w_last;
  assign cap   = live && i_blk_en && !oc_tc;

  // Count completes either already or with this capture.
  assign oc_hit = oc_tc ||
    (cap && (oc == OC_W'(N_OUT - 1)));
  // wd lags idle cycles by one, so tc marks the last DRAIN cycle.
  assign wd_hit = wd_tc && !i_blk_en;

  seq_cnt #(.W(WA_W), .MAX(KK - 1)) u_wa (
    .i_clk, .i_rst_n,
    .i_clr (state == S_IDLE),
    .i_en  (w_iss),
    .o_q   (wa),
    .o_tc  (wa_tc)
  );

  seq_cnt #(.W(FA_W), .MAX(FMN - 1)) u_fa (
    .i_clk, .i_rst_n,
    .i_clr (state == S_IDLE),
    .i_en  (state == S_STREAM),
    .o_q   (fa),
    .o_tc  (fa_tc)
  );

  seq_cnt #(.W(OC_W), .MAX(N_OUT)) u_oc (
    .i_clk, .i_rst_n,
    .i_clr (state == S_IDLE),
    .i_en  (cap),
    .o_q   (oc),
    .o_tc  (oc_tc)
  );

  seq_cnt #(.W(WD_W), .MAX(TIMEOUT - 2)) u_wd (
    .i_clk, .i_rst_n,
    .i_clr (!live || i_blk_en),
    .i_en  (live),
    .o_q   (wd),
    .o_tc  (wd_tc)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (i_start) nxt = S_CLR;
      S_CLR:    if (ph) nxt = S_WLOAD;
      S_WLOAD:  if (w_last) nxt = S_GAP;
      S_GAP:    if (ph) nxt = S_STREAM;
      S_STREAM: if (fa_tc) nxt = S_DRAIN;
      S_DRAIN:  if (oc_hit || wd_hit) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      ph            <= 1'b0;
      w_last        <= 1'b0;
      o_weight_en   <= 1'b0;
      o_go          <= 1'b0;
      o_err         <= 1'b0;
      o_out_wr_en   <= 1'b0;
      o_out_wr_addr <= '0;
      o_out_wr_data <= '0;
    end else begin
      state       <= nxt;
      ph          <= ((state == S_CLR) ||
                      (state == S_GAP)) && !ph;
      w_last      <= (state == S_IDLE) ? 1'b0 :
                     (w_last || (w_iss && wa_tc));
      o_weight_en <= w_iss;
      o_go        <= live && (nxt != S_DONE);
      if ((state == S_IDLE) && i_start)
        o_err <= 1'b0;
      else if ((state == S_DRAIN) && (nxt == S_DONE))
        o_err <= !oc_hit;
      o_out_wr_en <= cap;
      if (cap) begin
        o_out_wr_addr <= oc[OA_W-1:0];
        o_out_wr_data <= i_blk_result;
      end
    end
  end

  assign o_busy        = (state != S_IDLE);
  assign o_done        = (state == S_DONE);
  assign o_blk_rst     = (state == S_IDLE) ||
                         (state == S_CLR) ||
                         (state == S_DONE);
  assign o_wt_rd_addr  = wa;
  assign o_fm_rd_addr  = fa;
  assign o_weight_data = i_wt_rd_data;
  assign o_fm_data     = i_fm_rd_data;

endmodule

// File: tb/tb_conv_blk_ctrl.sv
// Bench for conv_blk_ctrl: K=3, FM=6, conv and max-pool instances,
// table rows, random result patterns and an async reset sequence.
module tb_conv_blk_ctrl;
  import conv_pkg::*;

  localparam int TO     = 64;
  localparam int KK     = 9;
  localparam int FMN    = 36;
  localparam int ST_REL = 2 + (KK + 1) + 2;
  localparam int DR_REL = ST_REL + FMN;
  localparam int OFS    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start0, start1, blk_en;
  logic [47:0] blk_res;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_blk_ctrl_if #(.FM_W(30), .W_W(18), .ACC_W(48)) b0 ();
  conv_blk_ctrl_if #(.FM_W(30), .W_W(18), .ACC_W(48)) b1 ();
  assign b0.blk_en = blk_en;
  assign b0.blk_result = blk_res;
  assign b1.blk_en = blk_en;
  assign b1.blk_result = blk_res;

  logic busy0, done0, err0, wr_en0;
  logic busy1, done1, err1, wr_en1;
  logic [3:0] wa0, wa1, wr_addr0;
  logic [1:0] wr_addr1;
  logic [5:0] fa0, fa1;
  logic [47:0] wr_data0, wr_data1;
  logic [17:0] wt_q0, wt_q1;
  logic [29:0] fm_q0, fm_q1;
  logic [17:0] wt_mem [0:15];
  logic [29:0] fm_mem [0:63];

  always @(posedge clk) begin
    wt_q0 <= wt_mem[wa0];
    wt_q1 <= wt_mem[wa1];
    fm_q0 <= fm_mem[fa0];
    fm_q1 <= fm_mem[fa1];
  end

  conv_blk_ctrl #(
    .KERNEL_SIZE(3), .FM_SIZE(6), .PADDING(0),
    .STRIDE(1), .MAXPOOL(0), .FM_W(30), .W_W(18),
    .ACC_W(48), .TIMEOUT(TO)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0),
    .o_busy(busy0), .o_done(done0), .o_err(err0),
    .o_wt_rd_addr(wa0), .i_wt_rd_data(wt_q0),
    .o_fm_rd_addr(fa0), .i_fm_rd_data(fm_q0),
    .o_blk_rst(b0.blk_rst), .o_weight_en(b0.weight_en),
    .o_weight_data(b0.weight_data), .o_go(b0.go),
    .o_fm_data(b0.fm_data), .i_blk_en(b0.blk_en),
    .i_blk_result(b0.blk_result),
    .o_out_wr_en(wr_en0), .o_out_wr_addr(wr_addr0),
    .o_out_wr_data(wr_data0)
  );

  conv_blk_ctrl #(
    .KERNEL_SIZE(3), .FM_SIZE(6), .PADDING(0),
    .STRIDE(1), .MAXPOOL(1), .FM_W(30), .W_W(18),
    .ACC_W(48), .TIMEOUT(TO)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
    .o_busy(busy1), .o_done(done1), .o_err(err1),
    .o_wt_rd_addr(wa1), .i_wt_rd_data(wt_q1),
    .o_fm_rd_addr(fa1), .i_fm_rd_data(fm_q1),
    .o_blk_rst(b1.blk_rst), .o_weight_en(b1.weight_en),
    .o_weight_data(b1.weight_data), .o_go(b1.go),
    .o_fm_data(b1.fm_data), .i_blk_en(b1.blk_en),
    .i_blk_result(b1.blk_result),
    .o_out_wr_en(wr_en1), .o_out_wr_addr(wr_addr1),
    .o_out_wr_data(wr_data1)
  );

  int sel = 0;
  logic s_busy, s_done, s_err, s_rst, s_wen, s_go, s_wr;
  logic [17:0] s_wd;
  logic [29:0] s_fd;
  logic [3:0] s_wa;
  logic [47:0] s_wdat;

  always_comb begin
    if (sel == 0) begin
      s_busy = busy0; s_done = done0; s_err = err0;
      s_rst = b0.blk_rst; s_wen = b0.weight_en;
      s_go = b0.go; s_wd = b0.weight_data;
      s_fd = b0.fm_data; s_wr = wr_en0;
      s_wa = wr_addr0; s_wdat = wr_data0;
    end else begin
      s_busy = busy1; s_done = done1; s_err = err1;
      s_rst = b1.blk_rst; s_wen = b1.weight_en;
      s_go = b1.go; s_wd = b1.weight_data;
      s_fd = b1.fm_data; s_wr = wr_en1;
      s_wa = {2'b00, wr_addr1}; s_wdat = wr_data1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  bit en_at [0:511];
  logic [47:0] res_at [0:511];
  int ew_rel[$], ew_addr[$];
  logic [47:0] ew_dat[$];
  int e_done;
  bit e_err;

  task automatic fill(input int n, input int first,
                      input int gap, input bit ig);
    for (int i = 0; i < 512; i++) begin
      en_at[i] = 1'b0;
      res_at[i] = {16'($urandom), $urandom};
    end
    for (int k = 0; k < n; k++)
      en_at[first + OFS + k * gap] = 1'b1;
    if (ig) begin
      en_at[OFS - 1] = 1'b1;
      en_at[OFS + ST_REL - 2] = 1'b1;
      en_at[OFS + ST_REL - 1] = 1'b1;
    end
  endtask

  // Expected writes/done from the capture window and limit rules.
  task automatic model(input int n);
    int cnt = 0;
    int last = ST_REL - 1;
    ew_rel.delete(); ew_addr.delete(); ew_dat.delete();
    e_done = -1; e_err = 1'b0;
    for (int c = ST_REL; c < 400; c++) begin
      if (en_at[c + OFS]) begin
        last = c;
        if (cnt < n) begin
          ew_rel.push_back(c + 1);
          ew_addr.push_back(cnt);
          ew_dat.push_back(res_at[c + OFS]);
          cnt++;
        end
      end
      if (c >= DR_REL) begin
        if (cnt == n) begin
          e_done = c + 1; e_err = 1'b0; break;
        end
        if (c - last >= TO - 1) begin
          e_done = c + 1; e_err = 1'b1; break;
        end
      end
    end
  endtask

  task automatic drive_start(input bit v);
    start0 = (sel == 0) && v;
    start1 = (sel != 0) && v;
  endtask

  task automatic run_pass(input int s_sel, input int rs,
                          input int exp_wr, input bit exp_err);
    int s, rel, wi, gi, nd, drel;
    bit derr;
    int ow_rel[$], ow_addr[$];
    logic [47:0] ow_dat[$];
    sel = s_sel;
    model(s_sel == 1 ? 4 : 16);
    wi = 0; gi = 0; nd = 0; drel = -1; derr = 1'b0;
    @(negedge clk);
    s = cyc + 1;
    drive_start(1'b1);
    blk_en = en_at[OFS - 1];
    blk_res = res_at[OFS - 1];
    for (int r = 0; r <= e_done + 4; r++) begin
      @(negedge clk);
      rel = cyc - s;
      if (s_wen) begin
        chk("wt_seq", {32'(rel), 32'(s_wd)},
            {32'(3 + wi), 32'(wt_mem[wi])});
        wi++;
      end
      if (s_go) begin
        if (gi < FMN)
          chk("fm_seq", {32'(rel), 32'(s_fd)},
              {32'(ST_REL + 1 + gi), 32'(fm_mem[gi])});
        gi++;
      end
      if (s_wr) begin
        ow_rel.push_back(rel);
        ow_addr.push_back(int'(s_wa));
        ow_dat.push_back(s_wdat);
      end
      if (s_done) begin
        nd++; drel = rel; derr = s_err;
      end
      if (rel <= 2)
        chk("blk_rst_clr", 64'(s_rst), 64'(rel != 2));
      if (rel == 0)
        chk("err_clear_busy", {s_err, s_busy}, 2'b01);
      if (rel == e_done)
        chk("done_blk_rst", 64'(s_rst), 64'd1);
      if (rel == e_done + 2)
        chk("err_hold_idle", {s_err, s_busy},
            {e_err, 1'b0});
      drive_start(rel == rs);
      blk_en = en_at[rel + OFS];
      blk_res = res_at[rel + OFS];
    end
    drive_start(1'b0);
    blk_en = 1'b0;
    chk("wt_count", wi, KK);
    chk("go_count", gi, e_done - ST_REL - 1);
    chk("done_count", nd, 1);
    chk("done_cycle", drel, e_done);
    chk("err", 64'(derr), 64'(exp_err));
    chk("wr_count", ow_rel.size(), exp_wr);
    for (int i = 0; i < ow_rel.size() &&
                    i < ew_rel.size(); i++) begin
      chk("wr_rel_addr", {32'(ow_rel[i]), 32'(ow_addr[i])},
          {32'(ew_rel[i]), 32'(ew_addr[i])});
      chk("wr_data", 64'(ow_dat[i]), 64'(ew_dat[i]));
    end
  endtask

  typedef struct {
    int sel; int n; int first; int gap;
    int rs; bit ig; int ewr; bit eerr;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 16, 20, 2, -1, 1'b0, 16, 1'b0};
    tbl[1] = '{1,  5, 30, 3, -1, 1'b0,  4, 1'b0};
    tbl[2] = '{0, 16, 16, 2, 30, 1'b0, 16, 1'b0};
    tbl[3] = '{0, 10, 20, 3, -1, 1'b0, 10, 1'b1};
    tbl[4] = '{0, 16, 18, 2, -1, 1'b1, 16, 1'b0};
    for (int i = 0; i < 16; i++) wt_mem[i] = 18'(i + 1);
    for (int i = 0; i < 64; i++) fm_mem[i] = 30'($urandom);
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    blk_en = 1'b0; blk_res = '0;
    repeat (3) @(negedge clk);
    chk("rst_state0",
        {busy0, done0, err0, b0.weight_en, b0.go,
         wr_en0, b0.blk_rst, wa0, fa0, wr_addr0},
        {7'b0000001, 4'd0, 6'd0, 4'd0});
    chk("rst_state1",
        {busy1, done1, err1, b1.weight_en, b1.go,
         wr_en1, b1.blk_rst, wa1, fa1, wr_addr1},
        {7'b0000001, 4'd0, 6'd0, 2'd0});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      fill(tbl[i].n, tbl[i].first, tbl[i].gap, tbl[i].ig);
      run_pass(tbl[i].sel, tbl[i].rs,
               tbl[i].ewr, tbl[i].eerr);
      repeat (2) @(negedge clk);
    end

    // Async reset in WLOAD, then a fresh full pass.
    sel = 0;
    fill(16, 20, 2, 1'b0);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst",
           {busy0, done0, err0, b0.weight_en, b0.go,
            wr_en0, b0.blk_rst, wa0, fa0},
           {7'b0000001, 4'd0, 6'd0});
    @(negedge clk); rst_n = 1'b1;
    begin
      int nd = 0;
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        if (done0 || busy0) nd++;
      end
      chk("no_activity_after_rst", nd, 0);
    end
    run_pass(0, -1, 16, 1'b0);
    repeat (2) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      int s_sel;
      s_sel = int'($urandom_range(0, 1));
      fill(0, 0, 1, 1'b0);
      for (int c = 0; c < 80; c++)
        en_at[c + OFS] = ($urandom_range(0, 2) == 0);
      model(s_sel == 1 ? 4 : 16);
      run_pass(s_sel, -1, ew_rel.size(), e_err);
      repeat (2) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
